axi4_aw_qos_write_router: RTL and testbench

// - Parametrised write-path router: NUM_MASTERS AXI4 write masters to NUM_SLAVES slaves.
// - Routes AW, W and B channels. One write transaction in flight at a time.
// - Arbitration is by QoS, with round-robin tie-break.
// - Per-slave address decode, per-master write permission and INCR 4KB-boundary check;

---
 rtl/axi4_aw_qos_write_router.sv | 205 ++++++++++++++++++++
 tb/tb_axi4_aw_qos_write_router.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4_aw_qos_write_router.sv
// AXI4 write-path router: NUM_MASTERS masters to NUM_SLAVES slaves, one burst in flight,
// QoS arbitration with round-robin tie-break and an internal DECERR/SLVERR responder.
module axi4_aw_qos_write_router #(
   parameter int NUM_MASTERS = 2,
   parameter int NUM_SLAVES  = 3,
   parameter int ADDR_WIDTH  = 32,
   parameter int DATA_WIDTH  = 64,
   parameter int ID_WIDTH    = 4,
   parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0]  SLAVE_BASE   = {32'h0002_0000, 32'h0001_0000, 32'h0000_0000},
   parameter logic [NUM_SLAVES*8-1:0]           SLAVE_SZLOG2 = {8'd16, 8'd16, 8'd16},
   parameter logic [NUM_SLAVES*NUM_MASTERS-1:0] WR_ALLOW     = '1
) (
   input  logic                                aclk,
   input  logic                                areset,
   input  logic [NUM_MASTERS-1:0]              m_awvalid,
   output logic [NUM_MASTERS-1:0]              m_awready,
   input  logic [NUM_MASTERS*ADDR_WIDTH-1:0]   m_awaddr,
   input  logic [NUM_MASTERS*ID_WIDTH-1:0]     m_awid,
   input  logic [NUM_MASTERS*8-1:0]            m_awlen,
   input  logic [NUM_MASTERS*3-1:0]            m_awsize,
   input  logic [NUM_MASTERS*2-1:0]            m_awburst,
   input  logic [NUM_MASTERS*4-1:0]            m_awqos,
   input  logic [NUM_MASTERS-1:0]              m_wvalid,
   output logic [NUM_MASTERS-1:0]              m_wready,
   input  logic [NUM_MASTERS-1:0]              m_wlast,
   input  logic [NUM_MASTERS*DATA_WIDTH-1:0]   m_wdata,
   input  logic [NUM_MASTERS*DATA_WIDTH/8-1:0] m_wstrb,
   output logic [NUM_MASTERS-1:0]              m_bvalid,
   input  logic [NUM_MASTERS-1:0]              m_bready,
   output logic [NUM_MASTERS*2-1:0]            m_bresp,
   output logic [NUM_MASTERS*ID_WIDTH-1:0]     m_bid,
   output logic [NUM_SLAVES-1:0]               s_awvalid,
   input  logic [NUM_SLAVES-1:0]               s_awready,
   output logic [ADDR_WIDTH-1:0]               s_awaddr,
   output logic [ID_WIDTH-1:0]                 s_awid,
   output logic [7:0]                          s_awlen,
   output logic [2:0]                          s_awsize,
   output logic [1:0]                          s_awburst,
   output logic [3:0]                          s_awqos,
   output logic [NUM_SLAVES-1:0]               s_wvalid,
   input  logic [NUM_SLAVES-1:0]               s_wready,
   output logic [DATA_WIDTH-1:0]               s_wdata,
   output logic [DATA_WIDTH/8-1:0]             s_wstrb,
   output logic                                s_wlast,
   input  logic [NUM_SLAVES-1:0]               s_bvalid,
   output logic [NUM_SLAVES-1:0]               s_bready,
   input  logic [NUM_SLAVES*2-1:0]             s_bresp,
   input  logic [NUM_SLAVES*ID_WIDTH-1:0]      s_bid
);
   localparam int MIW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
   localparam int SIW = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
   localparam int SW  = DATA_WIDTH / 8;

   typedef enum logic [1:0] {S_IDLE, S_AW, S_W, S_B} state_t;

   state_t              state, state_nx;
   logic [MIW-1:0]      grant, rr_ptr, win;
   logic [SIW-1:0]      tgt, dec_tgt;
   logic                err, any_req, hit, b_hs;
   logic [1:0]          err_resp, dec_resp, bresp_sel;
   logic [ID_WIDTH-1:0] id_q, bid_sel;
   logic [3:0]          best_qos;
   logic [ADDR_WIDTH-1:0] w_addr;
   logic [7:0]          w_len;
   logic [2:0]          w_size;
   logic [1:0]          w_burst;
   logic [15:0]         span;

   // Strictly-greater compare over the rotated order keeps the earliest tied requester.
   always_comb begin
      int idx;
      idx      = 0;
      any_req  = 1'b0;
      win      = '0;
      best_qos = '0;
      for (int k = 0; k < NUM_MASTERS; k++) begin
         idx = (int'(rr_ptr) + k) % NUM_MASTERS;
         if (m_awvalid[idx] && (!any_req || m_awqos[idx*4 +: 4] > best_qos)) begin
            any_req  = 1'b1;
            win      = MIW'(idx);
            best_qos = m_awqos[idx*4 +: 4];
         end
      end
   end

   always_comb begin
      w_addr  = m_awaddr[int'(win)*ADDR_WIDTH +: ADDR_WIDTH];
      w_len   = m_awlen[int'(win)*8 +: 8];
      w_size  = m_awsize[int'(win)*3 +: 3];
      w_burst = m_awburst[int'(win)*2 +: 2];
      hit     = 1'b0;
      dec_tgt = '0;
      for (int s = NUM_SLAVES - 1; s >= 0; s--) begin
         if ((w_addr >> SLAVE_SZLOG2[s*8 +: 8]) ==
             (SLAVE_BASE[s*ADDR_WIDTH +: ADDR_WIDTH] >> SLAVE_SZLOG2[s*8 +: 8])) begin
            hit     = 1'b1;
            dec_tgt = SIW'(s);
         end
      end
      span = {4'b0, w_addr[11:0]} + ((16'(w_len) + 16'd1) << w_size);
      if (!hit || (w_burst == 2'b01 && span > 16'd4096))
         dec_resp = 2'b11;
      else if (!WR_ALLOW[int'(dec_tgt)*NUM_MASTERS + int'(win)])
         dec_resp = 2'b10;
      else
         dec_resp = 2'b00;
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge aclk) begin
      if (areset) begin
         state    <= S_IDLE;
         rr_ptr   <= '0;
         grant    <= '0;
         tgt      <= '0;
         err      <= 1'b0;
         err_resp <= 2'b00;
         id_q     <= '0;
      end else begin
         state <= state_nx;
         if (state == S_IDLE && any_req) begin
            grant    <= win;
            tgt      <= dec_tgt;
            err      <= (dec_resp != 2'b00);
            err_resp <= dec_resp;
            id_q     <= m_awid[int'(win)*ID_WIDTH +: ID_WIDTH];
         end
         if (b_hs)
            rr_ptr <= (grant == MIW'(NUM_MASTERS - 1)) ? '0 : grant + 1'b1;
      end
   end

   // NOTE: every output gets a default before the case so no path infers a latch.
   always_comb begin
      state_nx  = state;
      b_hs      = 1'b0;
      m_awready = '0;
      m_wready  = '0;
      m_bvalid  = '0;
      s_awvalid = '0;
      s_wvalid  = '0;
      s_bready  = '0;
      s_awaddr  = '0;
      s_awid    = '0;
      s_awlen   = '0;
      s_awsize  = '0;
      s_awburst = '0;
      s_awqos   = '0;
      s_wdata   = '0;
      s_wstrb   = '0;
      s_wlast   = 1'b0;
      bresp_sel = 2'b00;
      bid_sel   = '0;
      case (state)
         S_IDLE: if (any_req) state_nx = S_AW;
         S_AW: begin
            if (err) begin
               m_awready[grant] = 1'b1;
               state_nx         = S_W;
            end else begin
               s_awvalid[tgt]   = m_awvalid[grant];
               m_awready[grant] = s_awready[tgt];
               s_awaddr  = m_awaddr[int'(grant)*ADDR_WIDTH +: ADDR_WIDTH];
               s_awid    = m_awid[int'(grant)*ID_WIDTH +: ID_WIDTH];
               s_awlen   = m_awlen[int'(grant)*8 +: 8];
               s_awsize  = m_awsize[int'(grant)*3 +: 3];
               s_awburst = m_awburst[int'(grant)*2 +: 2];
               s_awqos   = m_awqos[int'(grant)*4 +: 4];
               if (m_awvalid[grant] && s_awready[tgt]) state_nx = S_W;
            end
         end
         S_W: begin
            if (err) begin
               m_wready[grant] = 1'b1;
            end else begin
               s_wvalid[tgt]   = m_wvalid[grant];
               m_wready[grant] = s_wready[tgt];
               s_wdata = m_wdata[int'(grant)*DATA_WIDTH +: DATA_WIDTH];
               s_wstrb = m_wstrb[int'(grant)*SW +: SW];
               s_wlast = m_wlast[grant];
            end
            if (m_wvalid[grant] && m_wready[grant] && m_wlast[grant]) state_nx = S_B;
         end
         S_B: begin
            if (err) begin
               m_bvalid[grant] = 1'b1;
               bresp_sel       = err_resp;
               bid_sel         = id_q;
            end else begin
               m_bvalid[grant] = s_bvalid[tgt];
               s_bready[tgt]   = m_bready[grant];
               bresp_sel       = s_bresp[int'(tgt)*2 +: 2];
               bid_sel         = s_bid[int'(tgt)*ID_WIDTH +: ID_WIDTH];
            end
            b_hs = m_bvalid[grant] && m_bready[grant];
            if (b_hs) state_nx = S_IDLE;
         end
         default: state_nx = S_IDLE;
      endcase
   end

   assign m_bresp = {NUM_MASTERS{bresp_sel}};
   assign m_bid   = {NUM_MASTERS{bid_sel}};

endmodule

// File: tb/tb_axi4_aw_qos_write_router.sv
// Self-checking bench for axi4_aw_qos_write_router: directed steps plus random rounds
// checked against an address-range / byte-count reference model.
module tb_axi4_aw_qos_write_router;
   logic aclk = 1'b0;
   logic areset;
   logic [1:0]   m_awvalid, m_awready, m_wvalid, m_wready, m_wlast, m_bvalid, m_bready;
   logic [63:0]  m_awaddr;
   logic [7:0]   m_awid, m_awqos;
   logic [15:0]  m_awlen, m_wstrb;
   logic [5:0]   m_awsize;
   logic [3:0]   m_awburst, m_bresp;
   logic [127:0] m_wdata;
   logic [7:0]   m_bid;
   logic [2:0]   s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
   logic [31:0]  s_awaddr;
   logic [3:0]   s_awid, s_awqos;
   logic [7:0]   s_awlen, s_wstrb;
   logic [2:0]   s_awsize;
   logic [1:0]   s_awburst;
   logic [63:0]  s_wdata;
   logic         s_wlast;
   logic [5:0]   s_bresp;
   logic [11:0]  s_bid;

   axi4_aw_qos_write_router #(
      .NUM_MASTERS(2), .NUM_SLAVES(3), .ADDR_WIDTH(32), .DATA_WIDTH(64), .ID_WIDTH(4),
      .SLAVE_BASE({32'h0002_0000, 32'h0001_0000, 32'h0000_0000}),
      .SLAVE_SZLOG2({8'd12, 8'd16, 8'd16}),
      .WR_ALLOW(6'b110111)
   ) dut (
      .aclk(aclk), .areset(areset),
      .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awaddr(m_awaddr), .m_awid(m_awid),
      .m_awlen(m_awlen), .m_awsize(m_awsize), .m_awburst(m_awburst), .m_awqos(m_awqos),
      .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wlast(m_wlast), .m_wdata(m_wdata),
      .m_wstrb(m_wstrb), .m_bvalid(m_bvalid), .m_bready(m_bready), .m_bresp(m_bresp),
      .m_bid(m_bid), .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr),
      .s_awid(s_awid), .s_awlen(s_awlen), .s_awsize(s_awsize), .s_awburst(s_awburst),
      .s_awqos(s_awqos), .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata),
      .s_wstrb(s_wstrb), .s_wlast(s_wlast), .s_bvalid(s_bvalid), .s_bready(s_bready),
      .s_bresp(s_bresp), .s_bid(s_bid)
   );

   always #5 aclk = ~aclk;

   typedef struct {
      bit         valid;
      logic [31:0] addr;
      logic [7:0] len;
      logic [2:0] size;
      logic [1:0] burst;
      logic [3:0] qos;
      logic [3:0] id;
   } req_t;

   // Reference memory map written as plain address ranges.
   longint base_tab [3] = '{64'h0, 64'h10000, 64'h20000};
   longint size_tab [3] = '{64'h10000, 64'h10000, 64'h1000};
   bit     allow_tab[3][2] = '{'{1'b1, 1'b1}, '{1'b1, 1'b0}, '{1'b1, 1'b1}};

   req_t req[2];
   int   rr_model = 0;
   int   total = 0;
   int   bad = 0;
   int   stall_w = 0;
   int   b_delay = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic void model_resp(input int m, output int tgt, output logic [1:0] resp);
      longint a, nbytes;
      a      = longint'(req[m].addr);
      nbytes = (longint'(req[m].len) + 1) * (longint'(1) << req[m].size);
      tgt    = -1;
      for (int s = 0; s < 3; s++)
         if (tgt < 0 && a >= base_tab[s] && a < base_tab[s] + size_tab[s]) tgt = s;
      if (tgt < 0 || (req[m].burst == 2'b01 && (a % 4096) + nbytes > 4096)) resp = 2'b11;
      else if (!allow_tab[tgt][m]) resp = 2'b10;
      else resp = 2'b00;
   endfunction

   // Highest qos wins; among equals, the smallest rotation distance from rr_model.
   function automatic int pick();
      int best_q, w, d, best_d;
      best_q = -1; w = -1; best_d = 99;
      for (int m = 0; m < 2; m++)
         if (req[m].valid && int'(req[m].qos) > best_q) best_q = int'(req[m].qos);
      for (int m = 0; m < 2; m++) begin
         d = (m - rr_model + 2) % 2;
         if (req[m].valid && int'(req[m].qos) == best_q && d < best_d) begin
            best_d = d; w = m;
         end
      end
      return w;
   endfunction

   task automatic arm(input int m, input logic [31:0] addr, input logic [7:0] len,
                      input logic [2:0] size, input logic [1:0] burst,
                      input logic [3:0] qos, input logic [3:0] id);
      req[m] = '{1'b1, addr, len, size, burst, qos, id};
      m_awvalid[m]        = 1'b1;
      m_awaddr[m*32 +: 32] = addr;
      m_awlen[m*8 +: 8]    = len;
      m_awsize[m*3 +: 3]   = size;
      m_awburst[m*2 +: 2]  = burst;
      m_awqos[m*4 +: 4]    = qos;
      m_awid[m*4 +: 4]     = id;
   endtask

   task automatic serve(input int m, input bit chk_lat);
      int tgt, beats, beat, stall, delay, other, c;
      logic [1:0] resp;
      logic [3:0] seen_id;
      logic [63:0] dbase;
      bit seen, err, sw;
      model_resp(m, tgt, resp);
      err   = (resp != 2'b00);
      beats = int'(req[m].len) + 1;
      other = 1 - m;
      dbase = {$urandom(), $urandom()};
      seen  = 1'b0;
      seen_id = '0;
      #1;
      for (c = 0; c < 40 && !seen; c++) begin
         if (c > 0) begin @(negedge aclk); #1; end
         check("w_before_aw", m_wready, 0);
         check("aw_other_ready", m_awready[other], 0);
         if (err) begin
            check("err_no_s_awvalid", s_awvalid, 0);
            seen = m_awready[m];
         end else if (s_awvalid != 3'b000) begin
            seen    = 1'b1;
            seen_id = s_awid;
            check("aw_target", s_awvalid, 64'(1 << tgt));
            check("aw_ready", m_awready[m], 1);
            check("aw_addr", s_awaddr, req[m].addr);
            check("aw_id", s_awid, req[m].id);
            check("aw_len", s_awlen, req[m].len);
            check("aw_size", s_awsize, req[m].size);
         end
         if (seen && chk_lat) check("aw_latency", c, 1);
      end
      check("aw_seen", seen, 1);
      @(negedge aclk);
      m_awvalid[m]  = 1'b0;
      req[m].valid  = 1'b0;
      beat  = 0;
      stall = stall_w;
      for (c = 0; c < 300 && beat < beats; c++) begin
         if (c > 0) @(negedge aclk);
         sw = (stall == 0);
         m_wvalid[m]          = 1'b1;
         m_wlast[m]           = (beat == beats - 1);
         m_wdata[m*64 +: 64]  = dbase + 64'(beat);
         m_wstrb[m*8 +: 8]    = 8'(beat) ^ 8'hA5;
         s_wready             = sw ? 3'b111 : 3'b000;
         #1;
         check("w_other_ready", m_wready[other], 0);
         if (err) begin
            check("err_no_s_wvalid", s_wvalid, 0);
            check("err_wready", m_wready[m], 1);
         end else begin
            check("w_target", s_wvalid, 64'(1 << tgt));
            check("w_ready", m_wready[m], sw);
            check("w_data", s_wdata, dbase + 64'(beat));
            check("w_strb", s_wstrb, 8'(beat) ^ 8'hA5);
            check("w_last", s_wlast, (beat == beats - 1));
         end
         if (m_wready[m]) beat++;
         if (stall > 0) stall--;
      end
      check("w_beats", beat, beats);
      @(negedge aclk);
      m_wvalid[m] = 1'b0;
      m_wlast[m]  = 1'b0;
      s_wready    = 3'b000;
      m_bready[m] = 1'b1;
      delay = b_delay;
      seen  = 1'b0;
      for (c = 0; c < 40 && !seen; c++) begin
         if (c > 0) @(negedge aclk);
         if (!err && delay == 0) begin
            s_bvalid                = 3'(1 << tgt);
            s_bresp[tgt*2 +: 2]     = 2'b00;
            s_bid[tgt*4 +: 4]       = seen_id;
         end
         #1;
         check("b_other_valid", m_bvalid[other], 0);
         check("b_valid", m_bvalid[m], err || delay == 0);
         check("s_bready", s_bready, err ? 64'h0 : 64'(1 << tgt));
         if (m_bvalid[m]) begin
            seen = 1'b1;
            check("b_resp", m_bresp[m*2 +: 2], resp);
            check("b_id", m_bid[m*4 +: 4], req[m].id);
         end
         if (delay > 0) delay--;
      end
      check("b_seen", seen, 1);
      @(negedge aclk);
      s_bvalid    = 3'b000;
      m_bready[m] = 1'b0;
      rr_model    = (m + 1) % 2;
   endtask

   task automatic run_round(input bit chk_lat);
      int w;
      w = pick();
      if (w >= 0) serve(w, chk_lat);
   endtask

   task automatic arm_random(input int m);
      logic [31:0] a;
      case ($urandom_range(0, 3))
         0: a = 32'h0000_0F00 + 32'($urandom_range(0, 255));
         1: a = 32'h0001_0000 + 32'($urandom_range(0, 'hFFFF));
         2: a = 32'h0002_0000 + 32'($urandom_range(0, 'hFFF));
         default: a = 32'h4000_0000 | 32'($urandom());
      endcase
      arm(m, a, 8'($urandom_range(0, 7)), 3'($urandom_range(0, 3)),
          2'($urandom_range(0, 2)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      areset = 1'b1;
      m_awvalid = '0; m_awaddr = '0; m_awid = '0; m_awlen = '0; m_awsize = '0;
      m_awburst = '0; m_awqos = '0; m_wvalid = '0; m_wlast = '0; m_wdata = '0;
      m_wstrb = '0; m_bready = 2'b11; s_awready = 3'b111; s_wready = 3'b111;
      s_bvalid = 3'b111; s_bresp = '1; s_bid = '1;
      req[0] = '{1'b0, '0, '0, '0, '0, '0, '0};
      req[1] = '{1'b0, '0, '0, '0, '0, '0, '0};
      repeat (3) @(negedge aclk);
      #1;
      check("rst_handshakes", {m_awready, m_wready, m_bvalid, s_awvalid, s_wvalid, s_bready}, 0);
      check("rst_s_payload", |{s_awaddr, s_awid, s_awlen, s_awsize, s_awburst, s_awqos,
                               s_wdata, s_wstrb, s_wlast}, 0);
      check("rst_b_payload", {m_bresp, m_bid}, 0);
      @(negedge aclk);
      areset = 1'b0;
      m_bready = '0; s_wready = '0; s_bvalid = '0; s_bresp = '0; s_bid = '0;

      // Basic INCR burst to slave 1.
      arm(0, 32'h0001_0000, 8'd3, 3'd3, 2'b01, 4'd0, 4'h5);
      run_round(1);
      // 4KB boundary: exactly at the edge, then one beat past it.
      arm(0, 32'h0000_0FF0, 8'd1, 3'd3, 2'b01, 4'd0, 4'h6);
      run_round(1);
      arm(0, 32'h0000_0FF0, 8'd2, 3'd3, 2'b01, 4'd0, 4'h7);
      run_round(1);
      // Unmapped address, then a write-permission violation.
      arm(1, 32'h8000_0000, 8'd0, 3'd2, 2'b01, 4'd0, 4'h8);
      run_round(1);
      arm(1, 32'h0001_0040, 8'd1, 3'd3, 2'b01, 4'd0, 4'hA);
      run_round(1);
      // Slave stalls W for 5 cycles and delays B.
      stall_w = 5; b_delay = 4;
      arm(1, 32'h0000_0200, 8'd2, 3'd3, 2'b01, 4'd0, 4'hC);
      run_round(1);
      stall_w = 0; b_delay = 0;
      // QoS priority with simultaneous requests.
      arm(0, 32'h0000_0100, 8'd0, 3'd3, 2'b01, 4'd2, 4'h1);
      arm(1, 32'h0001_0100, 8'd0, 3'd3, 2'b01, 4'd9, 4'h2);
      run_round(1);
      run_round(0);
      // Equal qos, four back-to-back rounds with both masters always requesting.
      arm(0, 32'h0000_0300, 8'd1, 3'd3, 2'b01, 4'd5, 4'h3);
      arm(1, 32'h0001_0300, 8'd1, 3'd3, 2'b01, 4'd5, 4'h4);
      for (int r = 0; r < 4; r++) begin
         int w;
         w = pick();
         serve(w, 0);
         arm(w, req[w].addr + 32'h40, 8'd1, 3'd3, 2'b01, 4'd5, 4'(r + 8));
      end
      run_round(0);
      run_round(0);
      // Randomized traffic with random slave back-pressure.
      for (int r = 0; r < 40; r++) begin
         for (int m = 0; m < 2; m++)
            if (!req[m].valid && $urandom_range(0, 1) == 1) arm_random(m);
         if (!req[0].valid && !req[1].valid) arm_random(int'($urandom_range(0, 1)));
         stall_w = int'($urandom_range(0, 2));
         b_delay = int'($urandom_range(0, 3));
         run_round(0);
      end
      while (req[0].valid || req[1].valid) run_round(0);
      stall_w = 0; b_delay = 0;
      // Reset in the middle of the W phase.
      arm(0, 32'h0001_0100, 8'd3, 3'd3, 2'b01, 4'd0, 4'h3);
      @(negedge aclk);
      @(negedge aclk);
      m_awvalid[0] = 1'b0;
      m_wvalid[0]  = 1'b1;
      m_wdata[63:0] = 64'h1234;
      s_wready     = 3'b111;
      #1;
      check("mid_w_ready", m_wready[0], 1);
      @(negedge aclk);
      areset = 1'b1;
      @(negedge aclk);
      #1;
      check("midrst_handshakes", {m_awready, m_wready, m_bvalid, s_awvalid, s_wvalid, s_bready}, 0);
      check("midrst_payload", |{s_awaddr, s_wdata, s_wlast, m_bresp, m_bid}, 0);
      areset = 1'b0;
      m_wvalid = '0;
      s_wready = '0;
      req[0].valid = 1'b0;
      rr_model = 0;
      @(negedge aclk);
      arm(0, 32'h0001_0200, 8'd1, 3'd3, 2'b01, 4'd0, 4'hE);
      run_round(1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
